cordic_polar2rect_seq: RTL

- Iterative (one micro-rotation per clock) CORDIC in rotation mode: converts a polar pair (r, phi) into rectangular (x, y).
- It is the inverse-direction companion of the pipelined rect-to-polar vectoring unit.
- It uses the same number formats: magnitude in the ×10000 fixed-point scale, angle in degrees ×10000, range ±1800000.
- It sits downstream of phase/magnitude processing and feeds x/y back to the datapath through a start/busy/done handshake.

---
 rtl/cordic_pkg.sv | 29 ++
 rtl/cordic_polar2rect_seq_if.sv | 24 ++
 rtl/cordic_gain_comp.sv | 19 +
 rtl/cordic_polar2rect_seq.sv | 134 +++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared constants and types for both CORDIC directions (rect->polar and polar->rect).
// Angles are degrees x10000 and magnitudes use the x10000 fixed-point scale.
package cordic_pkg;

  localparam int ATAN_N = 16;

  // atan(2^-i) in degrees x10000, i = 0..15
  localparam logic signed [31:0] ATAN_TAB [ATAN_N] = '{
    32'sd450000, 32'sd265650, 32'sd140362, 32'sd71250,
    32'sd35763,  32'sd17899,  32'sd8951,   32'sd4476,
    32'sd2238,   32'sd1119,   32'sd559,    32'sd279,
    32'sd140,    32'sd70,     32'sd35,     32'sd17
  };

  localparam logic signed [31:0] DEG90  = 32'sd900000;
  localparam logic signed [31:0] DEG180 = 32'sd1800000;

  // K ~= 2^-1 + 2^-3 - 2^-6 - 2^-9 = 0.607422
  localparam int GAIN_TERMS = 4;
  localparam int GAIN_SHIFT [GAIN_TERMS] = '{1, 3, 6, 9};
  localparam bit GAIN_SUB   [GAIN_TERMS] = '{1'b0, 1'b0, 1'b1, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ROTATE = 2'd1,
    ST_SCALE  = 2'd2
  } cordic_state_e;

endpackage

// File: rtl/cordic_polar2rect_seq_if.sv
// Start/busy/done handshake plus polar operands and rectangular results.
interface cordic_polar2rect_seq_if #(
  parameter int W = 32
);

  logic                start;
  logic signed [W-1:0] r_in;
  logic signed [W-1:0] phi_in;
  logic                busy;
  logic                done;
  logic signed [W-1:0] x_out;
  logic signed [W-1:0] y_out;

  modport master (
    output start, r_in, phi_in,
    input  busy, done, x_out, y_out
  );

  modport slave (
    input  start, r_in, phi_in,
    output busy, done, x_out, y_out
  );

endinterface

// File: rtl/cordic_gain_comp.sv
// Combinational CORDIC gain compensation: scaled = K * value using a shift-add sum.
module cordic_gain_comp
  import cordic_pkg::*;
#(
  parameter int W = 32
) (
  input  logic signed [W-1:0] value,
  output logic signed [W-1:0] scaled
);

  always_comb begin
    scaled = '0;
    for (int k = 0; k < GAIN_TERMS; k++) begin
      if (GAIN_SUB[k]) scaled = scaled - (value >>> GAIN_SHIFT[k]);
      else             scaled = scaled + (value >>> GAIN_SHIFT[k]);
    end
  end

endmodule

// File: rtl/cordic_polar2rect_seq.sv
// Iterative rotation-mode CORDIC: one micro-rotation per clock turns (r, phi) into
// gain-compensated (x, y), sequenced by an IDLE -> ROTATE -> SCALE controller.
module cordic_polar2rect_seq
  import cordic_pkg::*;
#(
  parameter int W    = 32,
  parameter int ITER = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  cordic_polar2rect_seq_if.slave bus
);

  localparam logic [3:0]          LAST   = 4'(ITER - 1);
  localparam logic signed [W-1:0] POS90  = W'(DEG90);
  localparam logic signed [W-1:0] NEG90  = -POS90;
  localparam logic signed [W-1:0] POS180 = W'(DEG180);
  localparam logic signed [W-1:0] NEG180 = -POS180;

  cordic_state_e state, next_state;

  logic [3:0]          cnt;
  logic signed [W-1:0] x_q, y_q, z_q;
  logic signed [W-1:0] x_res, y_res;
  logic                done_q;

  logic signed [W-1:0] phi_sat;
  logic signed [W-1:0] x_ld, y_ld, z_ld;
  logic signed [W-1:0] x_sh, y_sh, atan_v;
  logic signed [W-1:0] x_rot, y_rot, z_rot;
  logic signed [W-1:0] x_k, y_k;

  function automatic logic signed [W-1:0] sat_angle(input logic signed [W-1:0] a);
    logic signed [W-1:0] s;
    s = a;
    if (a > POS180)      s = POS180;
    else if (a < NEG180) s = NEG180;
    return s;
  endfunction

  // Load: clamp the angle, then pre-rotate by +/-90 deg so the residual is within CORDIC range
  always_comb begin
    phi_sat = sat_angle(bus.phi_in);
    x_ld    = bus.r_in;
    y_ld    = '0;
    z_ld    = phi_sat;
    if (phi_sat > POS90) begin
      x_ld = '0;
      y_ld = bus.r_in;
      z_ld = phi_sat - POS90;
    end else if (phi_sat < NEG90) begin
      x_ld = '0;
      y_ld = -bus.r_in;
      z_ld = phi_sat + POS90;
    end
  end

  // Micro-rotation: direction chosen by the sign of the residual angle
  always_comb begin
    x_sh   = x_q >>> cnt;
    y_sh   = y_q >>> cnt;
    atan_v = W'(ATAN_TAB[cnt]);
    if (!z_q[W-1]) begin
      x_rot = x_q - y_sh;
      y_rot = y_q + x_sh;
      z_rot = z_q - atan_v;
    end else begin
      x_rot = x_q + y_sh;
      y_rot = y_q - x_sh;
      z_rot = z_q + atan_v;
    end
  end

  cordic_gain_comp #(.W(W)) u_gain_x (.value(x_q), .scaled(x_k));
  cordic_gain_comp #(.W(W)) u_gain_y (.value(y_q), .scaled(y_k));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (bus.start) next_state = ST_ROTATE;
      ST_ROTATE: if (cnt == LAST) next_state = ST_SCALE;
      ST_SCALE:  next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      x_q    <= '0;
      y_q    <= '0;
      z_q    <= '0;
      x_res  <= '0;
      y_res  <= '0;
      done_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            x_q <= x_ld;
            y_q <= y_ld;
            z_q <= z_ld;
            cnt <= '0;
          end
        end
        ST_ROTATE: begin
          x_q <= x_rot;
          y_q <= y_rot;
          z_q <= z_rot;
          cnt <= cnt + 4'd1;
        end
        ST_SCALE: begin
          x_res  <= x_k;
          y_res  <= y_k;
          done_q <= 1'b1;
          cnt    <= '0;
        end
        default: done_q <= 1'b0;
      endcase
    end
  end

  assign bus.busy  = (state != ST_IDLE);
  assign bus.done  = done_q;
  assign bus.x_out = x_res;
  assign bus.y_out = y_res;

endmodule
